// File: rtl/multiply_divide_unit_pkg.sv
// Shared op codes, state encoding and decode helpers for the
// iterative multiply/divide unit.
package multiply_divide_unit_pkg;

    localparam int MD_OP_WIDTH = 3;

    localparam logic [MD_OP_WIDTH-1:0] MD_OP_MUL  = 3'd0;
    localparam logic [MD_OP_WIDTH-1:0] MD_OP_MULU = 3'd1;
    localparam logic [MD_OP_WIDTH-1:0] MD_OP_DIV  = 3'd2;
    localparam logic [MD_OP_WIDTH-1:0] MD_OP_DIVU = 3'd3;
    localparam logic [MD_OP_WIDTH-1:0] MD_OP_MTHI = 3'd4;
    localparam logic [MD_OP_WIDTH-1:0] MD_OP_MTLO = 3'd5;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2
    } md_state_t;

    function automatic logic md_is_arith(input logic [MD_OP_WIDTH-1:0] op);
        return (op == MD_OP_MUL) || (op == MD_OP_MULU) ||
               (op == MD_OP_DIV) || (op == MD_OP_DIVU);
    endfunction

    function automatic logic md_is_signed(input logic [MD_OP_WIDTH-1:0] op);
        return (op == MD_OP_MUL) || (op == MD_OP_DIV);
    endfunction

    function automatic logic md_is_div(input logic [MD_OP_WIDTH-1:0] op);
        return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
    endfunction

endpackage

// File: rtl/multiply_divide_unit.sv
// Iterative one-bit-per-cycle multiply/divide unit owning HI/LO.
// Multiply and divide share one accumulator, operand register and counter.
module multiply_divide_unit
    import multiply_divide_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [MD_OP_WIDTH-1:0] op,
    input  logic [DATA_WIDTH-1:0]  rs,
    input  logic [DATA_WIDTH-1:0]  rt,
    input  logic                   flush,
    output logic                   busy,
    output logic                   done,
    output logic [DATA_WIDTH-1:0]  hi,
    output logic [DATA_WIDTH-1:0]  lo
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    md_state_t state;
    md_state_t state_next;

    logic [2*W-1:0] acc;
    logic [W-1:0]   opnd;
    logic [CW-1:0]  cnt;
    logic           div_mode;
    logic           neg_res;
    logic           neg_rem;
    logic           div_zero;

    logic           accept;
    logic           op_signed;
    logic [W-1:0]   abs_rs;
    logic [W-1:0]   abs_rt;
    logic [2*W-1:0] step_acc;
    logic [W:0]     mul_sum;
    logic [W:0]     rem_sh;
    logic [W:0]     rem_diff;
    logic [2*W-1:0] prod;
    logic [W-1:0]   fix_hi;
    logic [W-1:0]   fix_lo;

    assign busy      = (state != MD_IDLE);
    assign accept    = (state == MD_IDLE) && start && !flush;
    assign op_signed = md_is_signed(op);
    assign abs_rs    = (op_signed && rs[W-1]) ? -rs : rs;
    assign abs_rt    = (op_signed && rt[W-1]) ? -rt : rt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= MD_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            MD_IDLE: begin
                if (accept && md_is_arith(op)) begin
                    state_next = MD_CALC;
                end
            end
            MD_CALC: begin
                if (flush) begin
                    state_next = MD_IDLE;
                end else if (cnt == LAST) begin
                    state_next = MD_FIX;
                end
            end
            MD_FIX: begin
                state_next = MD_IDLE;
            end
            default: begin
                state_next = MD_IDLE;
            end
        endcase
    end

    // Multiply: add multiplicand into the upper half, shift right.
    // Divide: shift left, trial-subtract divisor from the remainder.
    always_comb begin
        mul_sum  = {1'b0, acc[2*W-1:W]} + {1'b0, (acc[0] ? opnd : '0)};
        rem_sh   = {acc[2*W-1:W], acc[W-1]};
        rem_diff = rem_sh - {1'b0, opnd};
        step_acc = {mul_sum, acc[W-1:1]};
        if (div_mode) begin
            if (!rem_diff[W]) begin
                step_acc = {rem_diff[W-1:0], acc[W-2:0], 1'b1};
            end else begin
                step_acc = {rem_sh[W-1:0], acc[W-2:0], 1'b0};
            end
        end
    end

    // Divide by zero leaves |rs| as remainder; restoring its sign gives rs back.
    always_comb begin
        prod   = neg_res ? -acc : acc;
        fix_hi = prod[2*W-1:W];
        fix_lo = prod[W-1:0];
        if (div_mode) begin
            fix_hi = neg_rem ? -acc[2*W-1:W] : acc[2*W-1:W];
            fix_lo = (neg_res && !div_zero) ? -acc[W-1:0] : acc[W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            opnd     <= '0;
            cnt      <= '0;
            div_mode <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                MD_IDLE: begin
                    if (accept) begin
                        if (md_is_arith(op)) begin
                            div_mode <= md_is_div(op);
                            neg_res  <= op_signed && (rs[W-1] ^ rt[W-1]);
                            neg_rem  <= op_signed && rs[W-1];
                            div_zero <= (rt == '0);
                            cnt      <= '0;
                            if (md_is_div(op)) begin
                                acc  <= {{W{1'b0}}, abs_rs};
                                opnd <= abs_rt;
                            end else begin
                                acc  <= {{W{1'b0}}, abs_rt};
                                opnd <= abs_rs;
                            end
                        end else if (op == MD_OP_MTHI) begin
                            hi <= rs;
                        end else if (op == MD_OP_MTLO) begin
                            lo <= rs;
                        end
                    end
                end
                MD_CALC: begin
                    if (!flush) begin
                        acc <= step_acc;
                        cnt <= cnt + 1'b1;
                    end
                end
                MD_FIX: begin
                    if (!flush) begin
                        hi   <= fix_hi;
                        lo   <= fix_lo;
                        done <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/multiply_divide_unit.md
# multiply_divide_unit

Multi-cycle multiply/divide responder that owns the HI/LO register pair. Accepts MUL/MULU/DIV/DIVU/MTHI/MTLO requests from the execute stage and computes products and quotients iteratively, one bit per cycle. It reports `busy` so the pipeline can stall MFHI/MFLO and new multiply/divide issues. HI/LO are read combinationally by the ALU's move-from path.

## Interface
- `DATA_WIDTH`, 32, operand/HI/LO width; iteration count equals DATA_WIDTH.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request valid; sampled only when `busy`=0.
- `op`  in  3  `MD_OP_*` code from the shared package.
- `rs`  in  DATA_WIDTH  multiplicand/dividend, or MTHI/MTLO source.
- `rt`  in  DATA_WIDTH  multiplier/divisor.
- `flush`  in  1  synchronous abort of an in-flight operation.
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse: HI/LO were just updated by MUL/DIV.
- `hi`  out  DATA_WIDTH  HI register.
- `lo`  out  DATA_WIDTH  LO register.

## Operation
- States: IDLE, CALC, FIX. `busy` = (state != IDLE).
- IDLE with `start`=1 and op in {MUL, MULU, DIV, DIVU}:
  - latch absolute values for signed ops (raw values for unsigned ops);
  - latch result-sign flags;
  - clear the iteration counter;
  - go to CALC.
- IDLE with `start`=1 and op = MTHI/MTLO: `hi`/`lo` = `rs` at that edge. Stay IDLE, no `busy`, no `done`.
- Undefined op codes: ignored.
- CALC: one iteration per cycle.
  - Multiply: shift-add into a 2·DATA_WIDTH accumulator.
  - Divide: restoring shift-subtract, with the remainder in the upper half and the quotient in the lower half.
  - After DATA_WIDTH iterations, go to FIX.
- FIX: apply sign correction, write `hi`/`lo`, assert `done` for the next cycle, go to IDLE.
- Signed multiply: 2·DATA_WIDTH product is negated if operand signs differ. `{hi,lo}` = full product.
- Signed divide truncates toward zero:
  - quotient (`lo`) negated if signs differ;
  - remainder (`hi`) takes the sign of the dividend.
- Divide by zero (DIV or DIVU): `lo` = all ones, `hi` = `rs` unmodified, no sign correction. Latency unchanged.
- Overflow case DIV 0x80000000 / 0xFFFFFFFF: `lo` = 0x80000000, `hi` = 0.
- `start` while `busy`=1: ignored, no queuing. The stall is the issuer's responsibility.
- `flush` in CALC/FIX: state goes to IDLE at that edge, `hi`/`lo` are not written, no `done`.
  - `flush` has priority over FIX completion.
  - `flush` in IDLE with `start` also blocks acceptance, including MTHI/MTLO.

## Timing
- Reset values (asynchronous on `rst_n`=0): state IDLE, `busy` 0, `done` 0, `hi` 0, `lo` 0. Reset during CALC aborts with no write.
- Accept edge E0 → CALC. Iterations run on edges E1..E32; FIX follows E32.
- E33 writes `hi`/`lo` and returns to IDLE.
- `busy` is high for exactly 33 cycles (after E0 through E33).
- `done` is high in the cycle after E33, coincident with `busy` falling. A new `start` may be accepted at that same edge.
- MTHI/MTLO: 1-cycle write, visible on `hi`/`lo` in the cycle after the accept edge.
- `hi`/`lo` are stable for the whole time `busy`=1. An MFHI during `busy` must be stalled by the issuer.

## Structure
- Shared package holds the `MD_OP_*` constants: MUL=0, MULU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; all other codes unused.
- Shared package also holds the `MD_OP_WIDTH`=3 define and the state encoding constants.
- Single module, no sub-module. Multiply and divide share one 2·DATA_WIDTH accumulator, one DATA_WIDTH operand register and a `$clog2(DATA_WIDTH+1)`-bit counter.

## Test plan
- MUL rs=-3, rt=7 → `busy` high 33 cycles; at E33 `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB; `done` single pulse.
- MULU 0xFFFFFFFF × 0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001.
- DIV -7 / 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIV 0x80000000 / -1 → `lo`=0x80000000, `hi`=0.
- DIVU 7 / 0 → `lo`=0xFFFFFFFF, `hi`=7 after 33 busy cycles. A second `start` asserted mid-operation is ignored.
- MTHI 0x1234 then MTLO 0x5678 on consecutive cycles → `hi`=0x1234, `lo`=0x5678, `busy` never asserts.
- MUL 5×5 with `flush` at cycle 10 → `busy` low the next cycle, no `done`, HI/LO keep their prior values. The same test repeated with `rst_n` pulsed low at cycle 10 → all outputs read 0 immediately.
